fifo_axis_reader: RTL and testbench
===================================

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning AXI-Stream data width in bits.
REQ-002 SHALL have parameter KEEP_W, default DATA_W/8, meaning byte-enable width.
REQ-003 SHALL have parameter FWORD_W, default DATA_W+KEEP_W+1, meaning packed FIFO word width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port fifo_dout  input  FWORD_W  FIFO read data, packed as {tlast, tkeep, tdata} MSB to LSB, valid one cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read strobe (standard mode, read latency 1).
REQ-009 SHALL have port m_axis_tdata  output  DATA_W  stream data.
REQ-010 SHALL have port m_axis_tkeep  output  KEEP_W  stream byte enables.
REQ-011 SHALL have port m_axis_tlast  output  1  end of frame.
REQ-012 SHALL have port m_axis_tvalid  output  1  stream valid.
REQ-013 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-014 SHALL have port frame_cnt  output  16  count of frames completed (tlast beats accepted), wraps at 16'hFFFF to 0.
REQ-015 SHALL have port busy  output  1  high while any word is buffered or in flight.

Function
REQ-016 SHALL keep a 2-entry output buffer and a 1-bit in-flight flag; credit = buffer occupancy + in-flight.
REQ-017 SHALL assert fifo_rd_en combinationally when fifo_empty=0, rst=0 and credit < 2, or when credit = 2 and a beat is accepted this cycle (tvalid & tready).
REQ-018 SHALL set in-flight on the cycle after fifo_rd_en and capture fifo_dout into the buffer tail on that cycle.
REQ-019 SHALL present the buffer head on m_axis_*; tvalid = occupancy != 0.
REQ-020 SHALL pop the head on tvalid & tready; simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-021 SHALL hold tdata/tkeep/tlast stable while tvalid=1 and tready=0.
REQ-022 SHALL sustain one beat per cycle when FIFO non-empty and tready=1 continuously, after a 2-cycle initial latency (rd_en to tvalid).
REQ-023 SHALL never let occupancy exceed 2; a third word SHALL never be requested.
REQ-024 SHALL increment frame_cnt by 1 on each accepted beat with tlast=1; 16'hFFFF + 1 = 0.
REQ-025 SHALL pass tkeep unmodified; no check on tkeep contiguity.
REQ-026 SHALL drive busy = (occupancy != 0) | in-flight.
REQ-027 SHALL treat fifo_empty toggling mid-frame as a bubble only: tvalid drops, no data loss or reorder.

Reset
REQ-028 SHALL on rst=1 clear occupancy, in-flight, frame_cnt; m_axis_tvalid=0, fifo_rd_en=0, busy=0, m_axis_tdata/tkeep/tlast=0 the next cycle.
REQ-029 SHALL discard buffered and in-flight words on reset mid-frame; the first beat after reset is whatever the FIFO holds next.

Structure
REQ-030 SHALL place DATA_W/KEEP_W defaults and packed-word field offsets (TLAST_BIT, KEEP_LSB) in shared package udp_stack_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module axis_skid_buf2, instanced once; credit and frame logic stay in the top.

Verification
REQ-032 SHALL cover: 4 words preloaded, tready=1 -> fifo_rd_en cycles 0-3, tvalid cycles 2-5, data in order, frame_cnt=1 after tlast.
REQ-033 SHALL cover: 8 words, tready low for cycles 3-6 -> outputs stable, occupancy<=2, fifo_rd_en low while full, no loss.
REQ-034 SHALL cover: random tready 50%, random fifo_empty, 1000 frames -> scoreboard exact match, frame_cnt=1000.
REQ-035 SHALL cover: frame_cnt preset near wrap via 65537 single-beat frames -> frame_cnt=1.
REQ-036 SHALL cover: rst asserted with 2 buffered + 1 in flight -> next cycle tvalid=0, busy=0, frame_cnt=0.
REQ-037 SHALL cover: fifo_empty=1 throughout -> fifo_rd_en never asserted, tvalid=0.

Source files
------------

// File: rtl/udp_stack_pkg.sv
// Shared widths and packed FIFO word layout for the UDP stack datapath.
// A packed FIFO word is {tlast, tkeep, tdata}, MSB to LSB.
package udp_stack_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_KEEP_W = DEF_DATA_W / 8;

  // Field offsets depend on the instance widths, so they are also exposed as functions.
  function automatic int keep_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int tlast_bit(input int data_w, input int keep_w);
    return data_w + keep_w;
  endfunction

  localparam int KEEP_LSB  = keep_lsb(DEF_DATA_W);
  localparam int TLAST_BIT = tlast_bit(DEF_DATA_W, DEF_KEEP_W);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry in-order word buffer; slot0 is always the head.
// A push into a full buffer is ignored because upstream credit logic never issues one.
module axis_skid_buf2
  import udp_stack_pkg::*;
#(
  parameter int WORD_W = DEF_DATA_W + DEF_KEEP_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_word,
  input  logic              pop,
  output logic [WORD_W-1:0] head_word,
  output occ_e              occupancy
);

  logic [WORD_W-1:0] slot0;
  logic [WORD_W-1:0] slot1;

  assign head_word = slot0;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0     <= '0;
      slot1     <= '0;
      occupancy <= OCC_EMPTY;
    end else begin
      case (occupancy)
        OCC_EMPTY: begin
          if (push) begin
            slot0     <= push_word;
            occupancy <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            slot0 <= push_word;
          end else if (push) begin
            slot1     <= push_word;
            occupancy <= OCC_FULL;
          end else if (pop) begin
            occupancy <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            slot0 <= slot1;
            if (push) slot1 <= push_word;
            else      occupancy <= OCC_ONE;
          end
        end
        default: occupancy <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a standard-mode (latency 1) FIFO of packed {tlast, tkeep, tdata} words onto AXI-Stream,
// using buffer occupancy plus the in-flight read as credit so no more than two words are ever held.
module fifo_axis_reader
  import udp_stack_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int FWORD_W = DATA_W + KEEP_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FWORD_W-1:0] fifo_dout,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic [KEEP_W-1:0]  m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  localparam int KLSB = keep_lsb(DATA_W);
  localparam int TBIT = tlast_bit(DATA_W, KEEP_W);

  logic               in_flight;
  occ_e               occ;
  logic [FWORD_W-1:0] head;
  logic [1:0]         credit;
  logic               accept;

  axis_skid_buf2 #(.WORD_W(FWORD_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_word (fifo_dout),
    .pop       (accept),
    .head_word (head),
    .occupancy (occ)
  );

  assign m_axis_tvalid = (occ != OCC_EMPTY);
  assign m_axis_tdata  = head[DATA_W-1:0];
  assign m_axis_tkeep  = head[KLSB +: KEEP_W];
  assign m_axis_tlast  = head[TBIT];
  assign accept        = m_axis_tvalid & m_axis_tready;
  assign credit        = 2'(occ) + {1'b0, in_flight};
  assign busy          = m_axis_tvalid | in_flight;

  // A full credit count may still read when the head leaves this cycle, keeping one beat per cycle.
  assign fifo_rd_en = !rst && !fifo_empty &&
                      ((credit < 2'd2) || ((credit == 2'd2) && accept));

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      in_flight <= fifo_rd_en;
      if (accept && m_axis_tlast) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed and randomized checks of fifo_axis_reader against a latency-1 FIFO model.
module tb_fifo_axis_reader;

  localparam int DATA_W  = 64;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int FWORD_W = DATA_W + KEEP_W + 1;
  typedef logic [FWORD_W-1:0] word_t;

  logic               clk = 1'b0;
  logic               rst;
  word_t              fifo_dout = '0;
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [DATA_W-1:0]  m_axis_tdata;
  logic [KEEP_W-1:0]  m_axis_tkeep;
  logic               m_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [15:0]        frame_cnt;
  logic               busy;

  int compared   = 0;
  int mismatched = 0;

  fifo_axis_reader #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: ring memory, producer pointer owned by the stimulus, consumer pointer by the read port.
  word_t mem [0:4095];
  int    wr_ptr = 0;
  int    rd_ptr = 0;
  logic  hold_empty;

  assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  word_t       got_q[$];
  logic        obs_rd, obs_valid, obs_busy;
  logic [15:0] obs_frame;
  word_t       obs_word;
  word_t       prev_word = '0;
  logic        prev_stall = 1'b0;
  int          out_cnt = 0;
  int          rd_err = 0;
  int          stab_err = 0;
  int          over_err = 0;

  function automatic word_t mk(input int seq, input logic [KEEP_W-1:0] keep, input logic last);
    return {last, keep, 32'hC0DE_0000, seq[31:0]};
  endfunction

  task automatic push(input word_t w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr++;
  endtask

  // One clock: observe on the falling edge, return just after the rising edge for new stimulus.
  task automatic cycle();
    word_t ow;
    @(negedge clk);
    ow        = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    obs_rd    = fifo_rd_en;
    obs_valid = m_axis_tvalid;
    obs_busy  = busy;
    obs_frame = frame_cnt;
    obs_word  = ow;
    if (fifo_rd_en && fifo_empty) rd_err++;
    if (prev_stall && (!m_axis_tvalid || ow !== prev_word)) stab_err++;
    prev_stall = m_axis_tvalid && !m_axis_tready && !rst;
    prev_word  = ow;
    if (rst) begin
      out_cnt = 0;
    end else begin
      if (fifo_rd_en) out_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(ow);
        out_cnt--;
      end
      if (out_cnt > 3) over_err++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_axis_tready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    compared++; if (obs_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tvalid: got %0b expected 0", obs_valid); end
    compared++; if (obs_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", obs_busy); end
    compared++; if (obs_frame !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", obs_frame); end
    compared++; if (obs_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_en: got %0b expected 0", obs_rd); end
    compared++; if (obs_word !== '0) begin mismatched++; $display("[TB] FAIL reset_outputs: got %h expected 0", obs_word); end
    rst = 1'b0;
  endtask

  task automatic test_empty();
    int rd_cnt, tv_cnt;
    word_t g;
    word_t e [2];
    rd_cnt = 0;
    tv_cnt = 0;
    e[0] = mk(100, 8'hFF, 1'b0);
    e[1] = mk(101, 8'h3F, 1'b0);
    m_axis_tready = 1'b1;
    hold_empty = 1'b1;
    push(e[0]);
    push(e[1]);
    got_q.delete();
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (obs_rd) rd_cnt++;
      if (obs_valid) tv_cnt++;
    end
    compared++; if (rd_cnt !== 0) begin mismatched++; $display("[TB] FAIL empty_rd_en: got %0d strobes expected 0", rd_cnt); end
    compared++; if (tv_cnt !== 0) begin mismatched++; $display("[TB] FAIL empty_tvalid: got %0d valid cycles expected 0", tv_cnt); end
    hold_empty = 1'b0;
    for (int c = 0; c < 8; c++) cycle();
    compared++; if (got_q.size() !== 2) begin mismatched++; $display("[TB] FAIL empty_release_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      compared++; if (g !== e[i]) begin mismatched++; $display("[TB] FAIL empty_release_data[%0d]: got %h expected %h", i, g, e[i]); end
    end
  endtask

  task automatic test_preload4();
    logic [9:0] rd_mask, tv_mask;
    word_t g;
    word_t e [4];
    for (int i = 0; i < 4; i++) e[i] = mk(200 + i, (i == 3) ? 8'h07 : 8'hFF, i == 3);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) push(e[i]);
    got_q.delete();
    for (int c = 0; c < 10; c++) begin
      cycle();
      rd_mask[c] = obs_rd;
      tv_mask[c] = obs_valid;
    end
    compared++; if (rd_mask !== 10'b00_0000_1111) begin mismatched++; $display("[TB] FAIL preload_rd_en_cycles: got %b expected 0000001111", rd_mask); end
    compared++; if (tv_mask !== 10'b00_0011_1100) begin mismatched++; $display("[TB] FAIL preload_tvalid_cycles: got %b expected 0000111100", tv_mask); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      compared++; if (g !== e[i]) begin mismatched++; $display("[TB] FAIL preload_data[%0d]: got %h expected %h", i, g, e[i]); end
    end
    compared++; if (obs_frame !== 16'd1) begin mismatched++; $display("[TB] FAIL preload_frame_cnt: got %0d expected 1", obs_frame); end
    compared++; if (obs_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL preload_busy_idle: got %0b expected 0", obs_busy); end
  endtask

  task automatic test_backpressure();
    logic [15:0] rd_mask, tv_mask;
    word_t g;
    word_t e [8];
    for (int i = 0; i < 8; i++) e[i] = mk(300 + i, 8'hFF, i == 7);
    for (int i = 0; i < 8; i++) push(e[i]);
    got_q.delete();
    for (int c = 0; c < 16; c++) begin
      m_axis_tready = !(c >= 3 && c <= 6);
      cycle();
      rd_mask[c] = obs_rd;
      tv_mask[c] = obs_valid;
      if (c >= 3 && c <= 6) begin
        compared++; if (obs_word !== e[1]) begin mismatched++; $display("[TB] FAIL stall_head_c%0d: got %h expected %h", c, obs_word, e[1]); end
      end
    end
    compared++; if (rd_mask !== 16'h0F87) begin mismatched++; $display("[TB] FAIL bp_rd_en_cycles: got %h expected 0f87", rd_mask); end
    compared++; if (tv_mask !== 16'h3FFC) begin mismatched++; $display("[TB] FAIL bp_tvalid_cycles: got %h expected 3ffc", tv_mask); end
    for (int i = 0; i < 8; i++) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      compared++; if (g !== e[i]) begin mismatched++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, g, e[i]); end
    end
    compared++; if (obs_frame !== 16'd2) begin mismatched++; $display("[TB] FAIL bp_frame_cnt: got %0d expected 2", obs_frame); end
    compared++; if (over_err !== 0) begin mismatched++; $display("[TB] FAIL bp_outstanding: got %0d overflows expected 0", over_err); end
    compared++; if (stab_err !== 0) begin mismatched++; $display("[TB] FAIL bp_stability: got %0d changes expected 0", stab_err); end
  endtask

  task automatic test_reset_midframe();
    word_t g;
    word_t e [6];
    word_t x [4];
    for (int i = 0; i < 6; i++) e[i] = mk(400 + i, 8'hFF, i == 5);
    x[0] = e[0]; x[1] = e[3]; x[2] = e[4]; x[3] = e[5];
    for (int i = 0; i < 6; i++) push(e[i]);
    got_q.delete();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    // Buffer full: release one beat so a new read is issued, then reset on the next cycle.
    m_axis_tready = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    compared++; if (obs_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_rd_en: got %0b expected 0", obs_rd); end
    rst = 1'b0;
    cycle();
    compared++; if (obs_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_tvalid: got %0b expected 0", obs_valid); end
    compared++; if (obs_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %0b expected 0", obs_busy); end
    compared++; if (obs_frame !== 16'd0) begin mismatched++; $display("[TB] FAIL midrst_frame_cnt: got %0d expected 0", obs_frame); end
    for (int c = 0; c < 10; c++) cycle();
    compared++; if (got_q.size() !== 4) begin mismatched++; $display("[TB] FAIL midrst_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      compared++; if (g !== x[i]) begin mismatched++; $display("[TB] FAIL midrst_data[%0d]: got %h expected %h", i, g, x[i]); end
    end
    compared++; if (obs_frame !== 16'd1) begin mismatched++; $display("[TB] FAIL midrst_frame_after: got %0d expected 1", obs_frame); end
  endtask

  task automatic test_random();
    word_t exp_q[$];
    int pushed, cyc, bad, len, n;
    pushed = 0;
    cyc = 0;
    bad = 0;
    do_reset();
    got_q.delete();
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++)
        exp_q.push_back({b == len - 1, 8'($urandom()), 64'({$urandom(), $urandom()})});
    end
    while (got_q.size() < exp_q.size() && cyc < 30000) begin
      while (pushed < exp_q.size() && (wr_ptr - rd_ptr) < 16) begin
        push(exp_q[pushed]);
        pushed++;
      end
      m_axis_tready = ($urandom_range(0, 1) == 1);
      hold_empty = ($urandom_range(0, 3) == 0);
      cycle();
      cyc++;
    end
    m_axis_tready = 1'b0;
    hold_empty = 1'b0;
    cycle();
    cycle();
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
    compared++; if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL rand_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
    compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL rand_data: got %0d wrong beats expected 0", bad); end
    compared++; if (obs_frame !== 16'd1000) begin mismatched++; $display("[TB] FAIL rand_frame_cnt: got %0d expected 1000", obs_frame); end
    compared++; if (rd_err !== 0) begin mismatched++; $display("[TB] FAIL rand_read_when_empty: got %0d expected 0", rd_err); end
    compared++; if (over_err !== 0) begin mismatched++; $display("[TB] FAIL rand_outstanding: got %0d overflows expected 0", over_err); end
    compared++; if (stab_err !== 0) begin mismatched++; $display("[TB] FAIL rand_stability: got %0d changes expected 0", stab_err); end
  endtask

  task automatic test_wrap();
    int pushed, cyc;
    logic seen_ffff, seen_wrap;
    word_t g;
    pushed = 0;
    cyc = 0;
    seen_ffff = 1'b0;
    seen_wrap = 1'b0;
    do_reset();
    got_q.delete();
    hold_empty = 1'b0;
    m_axis_tready = 1'b1;
    while (got_q.size() < 65537 && cyc < 70000) begin
      while (pushed < 65537 && (wr_ptr - rd_ptr) < 8) begin
        push(mk(pushed, 8'hFF, 1'b1));
        pushed++;
      end
      cycle();
      cyc++;
      if (obs_frame == 16'hFFFF) seen_ffff = 1'b1;
      if (seen_ffff && obs_frame == 16'd0) seen_wrap = 1'b1;
    end
    m_axis_tready = 1'b0;
    cycle();
    cycle();
    compared++; if (got_q.size() !== 65537) begin mismatched++; $display("[TB] FAIL wrap_count: got %0d expected 65537", got_q.size()); end
    compared++; if (seen_ffff !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_reached_ffff: got %0b expected 1", seen_ffff); end
    compared++; if (seen_wrap !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_rolled_to_zero: got %0b expected 1", seen_wrap); end
    compared++; if (obs_frame !== 16'd1) begin mismatched++; $display("[TB] FAIL wrap_frame_cnt: got %0d expected 1", obs_frame); end
    g = (got_q.size() > 65536) ? got_q[65536] : '0;
    compared++; if (g !== mk(65536, 8'hFF, 1'b1)) begin mismatched++; $display("[TB] FAIL wrap_last_data: got %h expected %h", g, mk(65536, 8'hFF, 1'b1)); end
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m_axis_tready = 1'b0;
    hold_empty = 1'b0;
    test_reset();
    test_empty();
    test_preload4();
    test_backpressure();
    test_reset_midframe();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
